seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 126 ++++++++++++
 tb/tb_seq_detect_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial bit-pattern detector with a loadable pattern, selectable
//   overlapping or non-overlapping detection, and a saturating match counter.
//
// Ports
//   clk         : clock; all state updates on its rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : in_bit is sampled this cycle
//   in_bit      : serial data bit
//   load        : latch pat_in, flush history (same-cycle in_bit is dropped)
//   pat_in      : new pattern; bit PAT_W-1 is the oldest bit of the sequence
//   overlap     : 1 = overlapping detection, 0 = non-overlapping
//   clr_cnt     : synchronous clear of match_count (wins over an increment)
//   match       : registered one-cycle pulse on detection
//   match_count : saturating detection count
//   armed       : history holds at least PAT_W valid bits
//
// state | meaning
// ------+-----------------------------------------------
// FILL  | fewer than PAT_W bits accepted since flush/hit
// ARMED | PAT_W valid bits held; every accepted bit can hit
module seq_detect_param #(
  parameter int              PAT_W   = 4,
  parameter int              CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1001)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;

  logic [PAT_W-1:0] hist_nx;
  logic [FW-1:0]    fill_nx;
  logic             hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      hist_q  <= '0;
      pat_q   <= PAT_RST;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    hit     = 1'b0;

    // Candidate history/fill as if this cycle's bit were accepted; detection
    // looks at these so the completing bit itself takes part in the compare.
    hist_nx = {hist_q[PAT_W-2:0], in_bit};
    fill_nx = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;

    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_nx;
      fill_d = fill_nx;
      hit    = (fill_nx == FILL_FULL) && (hist_nx == pat_q);
      if (hit) begin
        match_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Non-overlapping: stale history bits are shifted out before fill
        // can reach PAT_W again, so only fill needs clearing.
        if (!overlap) fill_d = '0;
      end
    end

    if (clr_cnt) cnt_d = '0;

    case (state_q)
      ST_FILL: begin
        if (!load && in_valid && fill_d == FILL_FULL) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (load || (hit && !overlap)) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign armed       = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_bit, load, overlap, clr_cnt;
  logic [3:0] pat_in;
  logic       match;
  logic [1:0] match_count;
  logic       armed;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       m;
    logic [1:0] c;
    logic       a;
  } exp_t;

  exp_t sb[$];

  // reference model
  logic [3:0] m_hist, m_pat;
  int         m_fill, m_cnt;

  // most recent observed outputs and a shift record of match pulses
  logic        obs_m, obs_a;
  logic [1:0]  obs_c;
  logic [15:0] mh;

  seq_detect_param #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1001)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .load(load), .pat_in(pat_in), .overlap(overlap), .clr_cnt(clr_cnt),
    .match(match), .match_count(match_count), .armed(armed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = 4'b0000;
    m_fill = 0;
    m_pat  = 4'b1001;
    m_cnt  = 0;
  endtask

  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [3:0] p, input logic ov, input logic cl);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_bit = b; load = ld; pat_in = p; overlap = ov; clr_cnt = cl;
    e.m = 1'b0;
    if (ld) begin
      m_pat = p; m_hist = 4'b0000; m_fill = 0;
    end else if (v) begin
      m_hist = {m_hist[2:0], b};
      if (m_fill < 4) m_fill++;
      if (m_fill == 4 && m_hist == m_pat) begin
        e.m = 1'b1;
        if (m_cnt < 3) m_cnt++;
        if (!ov) m_fill = 0;
      end
    end
    if (cl) m_cnt = 0;
    e.c = 2'(m_cnt);
    e.a = (m_fill == 4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs_m = match; obs_c = match_count; obs_a = armed;
    mh = {mh[14:0], match};
    chk("sb_match", 16'(match), 16'(e.m));
    chk("sb_count", 16'(match_count), 16'(e.c));
    chk("sb_armed", 16'(armed), 16'(e.a));
    in_valid = 1'b0; load = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic stream(input logic [15:0] s, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) step(1'b1, s[i], 1'b0, 4'b0000, ov, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; load = 1'b0;
    pat_in = 4'b0000; overlap = 1'b0; clr_cnt = 1'b0; mh = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_match", 16'(match), 16'h0);
    chk("rst_count", 16'(match_count), 16'h0);
    chk("rst_armed", 16'(armed), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // overlapping: 1001001 -> hits after bits 4 and 7
    mh = '0;
    stream(16'b1001001, 7, 1'b1);
    chk("ovl_pulses", mh & 16'h7f, 16'b0001001);
    chk("ovl_count", 16'(obs_c), 16'd2);

    // clear counter, flush history
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    chk("clr_count", 16'(obs_c), 16'd0);
    step(1'b0, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b0);
    chk("flush_armed", 16'(obs_a), 16'd0);

    // non-overlapping: same stream -> hit after bit 4 only
    mh = '0;
    stream(16'b1001001, 7, 1'b0);
    chk("novl_pulses", mh & 16'h7f, 16'b0001000);
    chk("novl_count", 16'(obs_c), 16'd1);
    chk("novl_armed", 16'(obs_a), 16'd0);

    // gaps between bits are transparent; latency is one edge
    step(1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("gap_armed_b3", 16'(obs_a), 16'd0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("gap_match", 16'(obs_m), 16'd1);
    chk("gap_armed_b4", 16'(obs_a), 16'd1);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("gap_pulse_end", 16'(obs_m), 16'd0);

    // load wins over a same-cycle valid bit
    step(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    chk("load_armed", 16'(obs_a), 16'd0);
    chk("load_match", 16'(obs_m), 16'd0);
    mh = '0;
    stream(16'b0110, 4, 1'b1);
    chk("load_pulses", mh & 16'hf, 16'b0001);
    chk("load_count", 16'(obs_c), 16'd2);

    // saturation at 3 with five overlapping hits
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    mh = '0;
    stream(16'b0110110110110110, 16, 1'b1);
    chk("sat_pulses", mh, 16'b0001001001001001);
    chk("sat_count", 16'(obs_c), 16'd3);

    // clear on the edge of a hit: pulse still seen, count cleared
    stream(16'b11, 2, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    chk("clrhit_match", 16'(obs_m), 16'd1);
    chk("clrhit_count", 16'(obs_c), 16'd0);

    // async reset mid-stream
    stream(16'b110, 3, 1'b1);
    stream(16'b100, 3, 1'b1);
    chk("pre_rst_count", 16'(obs_c), 16'd1);
    chk("pre_rst_armed", 16'(obs_a), 16'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_match", 16'(match), 16'h0);
    chk("arst_count", 16'(match_count), 16'h0);
    chk("arst_armed", 16'(armed), 16'h0);
    #1 rst_n = 1'b1;
    mh = '0;
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("post_rst_match", 16'(obs_m), 16'd0);
    chk("post_rst_armed", 16'(obs_a), 16'd0);
    // pattern register is back at its reset value 1001
    stream(16'b001, 3, 1'b1);
    chk("post_rst_pulses", mh & 16'hf, 16'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
